// File: rtl/prog_prescaler.sv
// Programmable clock-enable prescaler.
// Divides enabled cycles by (per_act+1), emitting a one-cycle tick at terminal
// count. A square wave toggles on every tick. New periods are staged in a
// shadow register and applied only at a terminal count or a synchronous clear,
// so an interval in progress always finishes at the period it started with.
module prog_prescaler #(
    parameter int CNT_W          = 8,
    parameter int DEFAULT_PERIOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             per_ld,
    input  logic [CNT_W-1:0] per_in,
    output logic             tick,
    output logic             sq_out,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] per_act,
    output logic             per_pend
);

    localparam logic [CNT_W-1:0] DEF_PER = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] shadow;

    // Terminal-count pulse, decoded straight from registers.
    // NOTE: a continuous assign has no branches, so no latch can be inferred;
    // '>=' rather than '==' means a corrupted cnt still terminates the interval.
    assign tick = en && (cnt >= per_act);

    // Interval counter and square-wave phase.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // right-hand side reads the pre-edge value regardless of statement order.
        if (rst) begin
            cnt    <= '0;
            sq_out <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            sq_out <= 1'b0;
        end else if (tick) begin
            cnt    <= '0;
            sq_out <= ~sq_out;
        end else if (en) begin
            cnt    <= cnt + ONE;
        end
    end

    // Shadow / active period registers: stage on per_ld, apply at tick or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_act  <= DEF_PER;
            shadow   <= DEF_PER;
            per_pend <= 1'b0;
        end else if (clr) begin
            // The newest staged value takes effect at once on a clear.
            if (per_ld) begin
                per_act  <= per_in;
                shadow   <= per_in;
                per_pend <= 1'b0;
            end else if (per_pend) begin
                per_act  <= shadow;
                per_pend <= 1'b0;
            end
        end else if (per_ld && tick) begin
            // Load coinciding with terminal count governs the very next interval.
            per_act  <= per_in;
            shadow   <= per_in;
            per_pend <= 1'b0;
        end else if (per_ld) begin
            shadow   <= per_in;
            per_pend <= 1'b1;
        end else if (tick && per_pend) begin
            per_act  <= shadow;
            per_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_prescaler.sv
// Self-checking bench for prog_prescaler: directed scenarios followed by random
// traffic, all compared every cycle against an interval-based reference model.
module tb_prog_prescaler;

    localparam int CNT_W = 8;
    localparam int DEF_P = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic             per_ld = 1'b0;
    logic [CNT_W-1:0] per_in = '0;
    logic             tick;
    logic             sq_out;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_act;
    logic             per_pend;

    prog_prescaler #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .per_ld(per_ld),
        .per_in(per_in), .tick(tick), .sq_out(sq_out), .cnt(cnt),
        .per_act(per_act), .per_pend(per_pend)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed enabled cycles in the current interval, the
    // period in force, the staged period, and the square-wave level.
    int m_elapsed, m_period, m_staged, m_sq;
    bit m_staged_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_elapsed = 0; m_period = DEF_P; m_staged = DEF_P;
        m_staged_valid = 0; m_sq = 0;
    endtask

    // One clock cycle: drive inputs, compare all outputs mid-cycle, advance model.
    task automatic step(input bit e, input bit c, input bit l, input int p, output bit t_obs);
        bit done;
        en = e; clr = c; per_ld = l; per_in = CNT_W'(p);
        @(negedge clk);
        done = e && (m_elapsed >= m_period);
        check("tick",     tick,     done);
        check("cnt",      cnt,      m_elapsed);
        check("per_act",  per_act,  m_period);
        check("per_pend", per_pend, m_staged_valid);
        check("sq_out",   sq_out,   m_sq);
        t_obs = tick;
        if (c) begin
            m_elapsed = 0; m_sq = 0;
            if (l) begin m_period = p; m_staged_valid = 0; end
            else if (m_staged_valid) begin m_period = m_staged; m_staged_valid = 0; end
        end else begin
            if (done) begin m_elapsed = 0; m_sq = 1 - m_sq; end
            else if (e) m_elapsed++;
            if (l && done) begin m_period = p; m_staged_valid = 0; end
            else if (l) begin m_staged = p; m_staged_valid = 1; end
            else if (done && m_staged_valid) begin m_period = m_staged; m_staged_valid = 0; end
        end
        @(posedge clk); #1;
    endtask

    // Apply en pattern repeatedly; count enabled cycles until a tick is seen.
    task automatic enabled_cycles_to_tick(input bit [3:0] pat, input int plen, output int n);
        bit t;
        int i;
        n = 0; i = 0;
        for (int k = 0; k < 400; k++) begin
            step(pat[i], 0, 0, 0, t);
            if (pat[i]) n++;
            i = (i + 1) % plen;
            if (t) return;
        end
        n = -1;
    endtask

    task automatic set_period(input int p);
        bit t;
        step(1, 1, 1, p, t);
    endtask

    bit t;
    int n;
    int sq_toggles;

    initial begin
        model_reset();
        // Reset state.
        @(negedge clk);
        check("rst_cnt", cnt, 0);
        check("rst_per_act", per_act, DEF_P);
        check("rst_per_pend", per_pend, 0);
        check("rst_sq", sq_out, 0);
        check("rst_tick", tick, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Default period: first tick on 11th enabled cycle, then every 11.
        enabled_cycles_to_tick(4'b0001, 1, n); check("first_tick_default", n, 11);
        check("sq_after_tick1", sq_out, 1);
        enabled_cycles_to_tick(4'b0001, 1, n); check("second_tick_default", n, 11);
        check("sq_after_tick2", sq_out, 0);

        // Period 3, reload to 5 at cnt=1: old interval completes, then 6 cycles.
        set_period(3);
        step(1, 0, 0, 0, t);               // cnt 0
        step(1, 0, 1, 5, t);               // cnt 1, stage 5
        check("pend_after_ld", per_pend, 1);
        check("act_still_3", per_act, 3);
        enabled_cycles_to_tick(4'b0001, 1, n); check("old_interval_end", n, 2);
        check("act_now_5", per_act, 5);
        check("pend_cleared", per_pend, 0);
        enabled_cycles_to_tick(4'b0001, 1, n); check("new_interval_6", n, 6);

        // Load 0 coincident with a tick: tick every enabled cycle after.
        while (m_elapsed < m_period) step(1, 0, 0, 0, t);
        step(1, 0, 1, 0, t);
        check("ld0_on_tick", t, 1);
        check("per_act_zero", per_act, 0);
        sq_toggles = 0;
        for (int k = 0; k < 6; k++) begin
            logic prev;
            prev = sq_out;
            step(1, 0, 0, 0, t);
            if (t && (sq_out != prev)) sq_toggles++;
        end
        check("period0_toggles", sq_toggles, 6);

        // Period 4 with en pattern 1,0,0,1: still 5 enabled cycles per tick.
        set_period(4);
        enabled_cycles_to_tick(4'b1001, 4, n); check("gated_interval_a", n, 5);
        enabled_cycles_to_tick(4'b1001, 4, n); check("gated_interval_b", n, 5);
        // Reach cnt=4 then hold en low: no tick.
        while (m_elapsed < 4) step(1, 0, 0, 0, t);
        step(0, 0, 0, 0, t); check("no_tick_en0", t, 0);
        step(0, 0, 0, 0, t); check("cnt_frozen", cnt, 4);

        // Clear at cnt=7 with pending shadow=2 and en=0.
        set_period(9);
        while (m_elapsed < 7) step(1, 0, 0, 0, t);
        step(0, 0, 1, 2, t);
        check("pend_before_clr", per_pend, 1);
        step(0, 1, 0, 0, t);
        @(negedge clk);
        check("clr_cnt", cnt, 0);
        check("clr_sq", sq_out, 0);
        check("clr_per_act", per_act, 2);
        check("clr_pend", per_pend, 0);
        check("clr_tick", tick, 0);
        @(posedge clk); #1;

        // Async reset mid-count with a pending load.
        set_period(6);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, t);
        step(1, 0, 1, 9, t);
        #2 rst = 1'b1;
        #1;
        check("arst_cnt", cnt, 0);
        check("arst_per_act", per_act, DEF_P);
        check("arst_pend", per_pend, 0);
        check("arst_sq", sq_out, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        enabled_cycles_to_tick(4'b0001, 1, n); check("post_arst_interval", n, 11);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            bit e, c, l;
            int p;
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            l = ($urandom_range(0, 12) == 0);
            p = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            step(e, c, l, p, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_prescaler.md
Name: prog_prescaler

Overview:
- Runtime-programmable successor of the fixed prescaler used to pace the Supercar light sweep.
- Divides enabled clock cycles by (period+1) and emits a one-cycle tick.
- The period register is double-buffered, so speed changes take effect glitch-free at the next terminal count.
- Adds an optional square-wave output, a synchronous clear, and an exported count for cascading or debug.

Parameters:
- CNT_W, 8, width of the counter and period registers; max period = 2^CNT_W-1; must be >= 1.
- DEFAULT_PERIOD, 10, period loaded at reset; must be <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; low freezes counter, sq_out, and tick generation.
- clr  in  1  synchronous clear of count and square phase.
- per_ld  in  1  one-cycle strobe; captures per_in into the shadow register.
- per_in  in  CNT_W  new period value.
- tick  out  1  terminal-count pulse.
- sq_out  out  1  toggles on every tick; 50% duty at 2*(period+1) enabled cycles.
- cnt  out  CNT_W  current counter value.
- per_act  out  CNT_W  period currently in use.
- per_pend  out  1  shadow value loaded but not yet applied.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, per_act=DEFAULT_PERIOD, shadow=DEFAULT_PERIOD.
  - per_pend=0, sq_out=0, hence tick=0.
- tick is combinational from registers: tick = en && (cnt >= per_act).
  - The >= comparison is defensive only; cnt > per_act is unreachable in normal operation.
  - tick is never asserted while en=0.
- Counting, with clr=0 and en=1:
  - If tick: cnt<=0 and sq_out<=~sq_out.
  - Otherwise: cnt<=cnt+1.
- With en=0 and clr=0: cnt and sq_out hold. per_ld is still accepted.
- Tick rate: with continuous en, tick is high for exactly 1 cycle every per_act+1 cycles.
  - The first tick after reset or clear occurs when cnt reaches per_act, i.e. the (per_act+1)-th enabled cycle.
- Period 0: tick is high on every enabled cycle, cnt stays 0, and sq_out toggles every enabled cycle.
- Shadow load:
  - per_ld=1 sets shadow<=per_in and per_pend<=1.
  - A later per_ld before application overwrites the shadow; only the last value is applied.
- Application of the shadow:
  - On a cycle with tick=1 and per_pend=1: per_act<=shadow, per_pend<=0.
  - per_act never changes mid-count, so the current interval always completes at the old period.
- per_ld in the same cycle as tick:
  - per_act<=per_in directly and per_pend<=0.
  - The new value governs the very next interval.
- clr=1 (highest priority, independent of en):
  - cnt<=0 and sq_out<=0.
  - If per_pend=1, or per_ld=1 in the same cycle, the newest value (per_in if per_ld, else shadow) is applied to per_act immediately, and per_pend<=0.
  - No tick-driven update occurs in a clr cycle, although tick may still read high combinationally in that cycle.
- Reset mid-operation: all state returns to reset values at once. A pending shadow value is discarded.
- Arithmetic: cnt increments modulo 2^CNT_W, but wrap is unreachable because the terminal compare fires at or before the maximum value.
- Implementation budget: counter, compare, shadow/active period registers, and toggle flop; about 150 lines.

Test Plan:
- Reset, then en=1 held with default period 10 -> first tick on the 11th enabled cycle (cnt=10), then every 11 cycles; sq_out toggles at each tick, giving a 22-cycle period.
- Period 3; at cnt=1 pulse per_ld with per_in=5 -> per_pend=1; the current interval ends at cnt=3; per_act=5 from the next cycle; per_pend=0; the following tick comes 6 cycles later.
- per_ld with per_in=0 coincident with a tick -> per_act=0 next cycle; tick and sq_out toggle every enabled cycle thereafter.
- en toggled 1,0,0,1 while counting at period 4 -> cnt and sq_out freeze during en=0; tick stays 0 even when cnt=4 and en=0; the total enabled-cycle count per tick remains 5.
- clr asserted at cnt=7 with per_pend=1 (shadow=2) and en=0 -> next cycle cnt=0, sq_out=0, per_act=2, per_pend=0, with no tick.
- rst asserted asynchronously mid-count with a pending load -> outputs return immediately to cnt=0, per_act=10, per_pend=0, sq_out=0.
